// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl
//   Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for a LEGv8 datapath whose
//   instruction and data memory share one port with a ready handshake.
//
// Parameters
//   MEM_TIMEOUT : wait cycles tolerated in FETCH/MEM before FAULT (0 = never)
//   TO_W        : wait counter width, 2**TO_W > MEM_TIMEOUT
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   run                     : keep executing; sampled at instruction boundaries
//   instr                   : IR contents, decoded in DECODE
//   zero                    : ALU zero flag (CBZ)
//   mem_ready               : shared memory port completion
//   imem_req, ir_write      : instruction fetch request / IR load
//   pc_write, pc_src        : PC update, 00 = PC+4, 01 = PC + branch offset
//   dmem_read, dmem_write   : data load / store request
//   reg_write, mem_to_reg   : register write enable / writeback source
//   alu_src, alu_op         : ALU B-operand select / operation
//   state, busy, fault      : FSM state, activity, sticky fault
//
// Optional feature (macro ARM_CTRL_PERF_EN)
//   retired      : instructions completed (wraps at 2**32)
//   stall_cycles : FETCH/MEM cycles spent waiting on mem_ready (wraps)
module arm_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        busy,
    output logic        fault
`ifdef ARM_CTRL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_B, C_CBZ, C_STUR, C_LDUR, C_ADD, C_SUB, C_AND, C_ORR, C_ILL
    } class_t;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    class_t          r_class;
    class_t          w_dec_class;
    logic [TO_W-1:0] r_wait;
    logic            w_wait_phase;
    logic            w_timeout;
    logic            w_done;
    logic [3:0]      w_alu_op;
    logic            w_alu_src;
    logic            w_unused;

    // Operand fields are consumed by the datapath, not by the sequencer.
    assign w_unused = ^instr[20:0];

    always_comb begin
        w_dec_class = C_ILL;
        if (instr[31:26] == 6'b000101) begin
            w_dec_class = C_B;
        end else if (instr[31:24] == 8'b10110100) begin
            w_dec_class = C_CBZ;
        end else begin
            case (instr[31:21])
                11'b11111000000: w_dec_class = C_STUR;
                11'b11111000010: w_dec_class = C_LDUR;
                11'b10001011000: w_dec_class = C_ADD;
                11'b11001011000: w_dec_class = C_SUB;
                11'b10001010000: w_dec_class = C_AND;
                11'b10101010000: w_dec_class = C_ORR;
                default:         w_dec_class = C_ILL;
            endcase
        end
    end

    assign w_wait_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    // mem_ready in the deadline cycle wins over the timeout.
    assign w_timeout    = (MEM_TIMEOUT != 0) && w_wait_phase && !mem_ready &&
                          (r_wait == TIMEOUT_V);

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: w_next = (w_dec_class == C_ILL) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                case (r_class)
                    C_ADD, C_SUB, C_AND, C_ORR: w_next = S_WB;
                    C_LDUR, C_STUR:             w_next = S_MEM;
                    C_B, C_CBZ:                 w_done = 1'b1;
                    default:                    w_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (r_class == C_LDUR) w_next = S_WB;
                    else                   w_done = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_WB:     w_done = 1'b1;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
        if (w_done) w_next = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_class <= C_NONE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_class <= w_dec_class;
            // Counts only while waiting in place; any state change clears it,
            // which also gives the clear-on-entry to FETCH/MEM.
            if (w_wait_phase && !mem_ready && (w_next == r_state))
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
        end
    end

    always_comb begin
        w_alu_op  = 4'b0000;
        w_alu_src = 1'b0;
        case (r_class)
            C_ADD:          w_alu_op = 4'b0010;
            C_SUB:          w_alu_op = 4'b0110;
            C_AND:          w_alu_op = 4'b0000;
            C_ORR:          w_alu_op = 4'b0001;
            C_LDUR, C_STUR: begin
                w_alu_op  = 4'b0010;
                w_alu_src = 1'b1;
            end
            C_B, C_CBZ:     w_alu_op = 4'b0111;
            default:        w_alu_op = 4'b0000;
        endcase
    end

    // Strobes decode from the registered state/class; FETCH completion and
    // CBZ are Mealy on mem_ready/zero, so these cannot be registered.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 4'b0000;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                alu_src = w_alu_src;
                alu_op  = w_alu_op;
                if (r_class == C_B) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end else if (r_class == C_CBZ) begin
                    pc_write = zero;
                    pc_src   = 2'b01;
                end
            end
            S_MEM: begin
                alu_src    = w_alu_src;
                alu_op     = w_alu_op;
                dmem_read  = (r_class == C_LDUR);
                dmem_write = (r_class == C_STUR);
            end
            S_WB: begin
                alu_src    = w_alu_src;
                alu_op     = w_alu_op;
                reg_write  = 1'b1;
                mem_to_reg = (r_class == C_LDUR);
            end
            default: ;
        endcase
    end

    assign state = r_state;
    assign busy  = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign fault = (r_state == S_FAULT);

`ifdef ARM_CTRL_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if (w_done)                     r_retired <= r_retired + 32'd1;
            if (w_wait_phase && !mem_ready) r_stall   <= r_stall + 32'd1;
        end
    end

    assign retired      = r_retired;
    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
module tb_arm_multicycle_ctrl;

    localparam int TMO = 15;

    localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3,
                           S_M = 3'd4, S_W = 3'd5, S_X = 3'd7;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_LD = 4,
                   K_ST = 5, K_B = 6, K_CBZ = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, dmem_read, dmem_write;
    logic        reg_write, mem_to_reg, alu_src, busy, fault;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
`ifdef ARM_CTRL_PERF_EN
    logic [31:0] retired, stall_cycles;
`endif

    int          n_checks = 0;
    int          n_err = 0;
    int unsigned exp_retired = 0;
    int unsigned exp_stall = 0;
    logic        at_idle = 1'b1;
    logic [18:0] obs;

    arm_multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .alu_op(alu_op), .state(state), .busy(busy),
        .fault(fault)
`ifdef ARM_CTRL_PERF_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {state, imem_req, ir_write, pc_write, pc_src, dmem_read,
                  dmem_write, reg_write, mem_to_reg, alu_src, alu_op, busy, fault};

    function automatic logic [18:0] ev(input logic [2:0] st, input logic im,
        input logic irw, input logic pcw, input logic [1:0] pcs, input logic dr,
        input logic dw, input logic rw, input logic m2r, input logic as,
        input logic [3:0] aop);
        return {st, im, irw, pcw, pcs, dr, dw, rw, m2r, as, aop,
                (st != S_I) && (st != S_X), st == S_X};
    endfunction

    function automatic logic [18:0] quiet(input logic [2:0] st);
        return ev(st, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endfunction

    function automatic int classify(input logic [31:0] w);
        if (w[31:26] == 6'b000101) return K_B;
        if (w[31:24] == 8'b10110100) return K_CBZ;
        case (w[31:21])
            11'b10001011000: return K_ADD;
            11'b11001011000: return K_SUB;
            11'b10001010000: return K_AND;
            11'b10101010000: return K_ORR;
            11'b11111000010: return K_LD;
            11'b11111000000: return K_ST;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] aop_of(input int k);
        case (k)
            K_SUB:      return 4'b0110;
            K_AND:      return 4'b0000;
            K_ORR:      return 4'b0001;
            K_B, K_CBZ: return 4'b0111;
            default:    return 4'b0010;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADD:   return {11'b10001011000, r[20:0]};
            K_SUB:   return {11'b11001011000, r[20:0]};
            K_AND:   return {11'b10001010000, r[20:0]};
            K_ORR:   return {11'b10101010000, r[20:0]};
            K_LD:    return {11'b11111000010, r[20:0]};
            K_ST:    return {11'b11111000000, r[20:0]};
            K_B:     return {6'b000101, r[25:0]};
            K_CBZ:   return {8'b10110100, r[23:0]};
            default: return r;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [18:0] e);
        n_checks++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, e);
        end
    endtask

    // Inputs are already applied (posedge+1); compare at negedge, advance.
    task automatic step(input string tag, input logic [18:0] e);
        @(negedge clk);
        chk(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        run = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_retired = 0;
        exp_stall = 0;
        at_idle = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        run = 1'b0;
        mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk(tag, quiet(S_I));
        release_reset();
    endtask

    task automatic fault_hold(input string tag);
        for (int i = 0; i < 3; i++) begin
            run = 1'b1;
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            instr = $urandom;
            step($sformatf("%s_hold%0d", tag, i), quiet(S_X));
        end
        apply_reset({tag, "_reset"});
    endtask

    task automatic chk_perf(input string tag);
`ifdef ARM_CTRL_PERF_EN
        n_checks++;
        assert (retired === exp_retired) else begin
            n_err++;
            $error("FAIL %s_retired observed=%0d expected=%0d", tag, retired, exp_retired);
        end
        n_checks++;
        assert (stall_cycles === exp_stall) else begin
            n_err++;
            $error("FAIL %s_stall observed=%0d expected=%0d", tag, stall_cycles, exp_stall);
        end
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    // Reference: one instruction walked phase by phase from the class rules.
    // fw/mw = unready cycles before mem_ready; > TMO means it never comes.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic rn, input int abort_at);
        int         k;
        logic [3:0] aop;
        logic       as, fin, ld, st;
        k   = classify(ins);
        aop = aop_of(k);
        ld  = (k == K_LD);
        st  = (k == K_ST);
        as  = ld || st;
        if (at_idle) begin
            run = 1'b1;
            mem_ready = 1'($urandom);
            instr = $urandom;
            step("idle_go", quiet(S_I));
        end
        for (int i = 0; i <= TMO; i++) begin
            mem_ready = (i == fw);
            run = 1'($urandom);
            instr = $urandom;
            zero = 1'($urandom);
            if (!mem_ready) exp_stall++;
            step($sformatf("fetch[%0d]", i), ev(S_F, 1'b1, mem_ready, mem_ready,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));
            if (mem_ready) break;
            if (i == TMO) begin
                fault_hold("fetch_timeout");
                return;
            end
        end
        instr = ins;
        mem_ready = 1'($urandom);
        run = 1'($urandom);
        step($sformatf("decode_%08h", ins), quiet(S_D));
        if (k == K_ILL) begin
            fault_hold("illegal");
            return;
        end
        instr = $urandom;
        mem_ready = 1'($urandom);
        zero = z;
        fin = (k == K_B) || (k == K_CBZ);
        run = fin ? rn : 1'($urandom);
        if (fin) exp_retired++;
        step($sformatf("exec_k%0d", k), ev(S_E, 1'b0, 1'b0,
             (k == K_B) || ((k == K_CBZ) && z), fin ? 2'b01 : 2'b00,
             1'b0, 1'b0, 1'b0, 1'b0, as, aop));
        if (fin) begin
            at_idle = !rn;
            return;
        end
        if (as) begin
            for (int i = 0; i <= TMO; i++) begin
                mem_ready = (i == mw);
                zero = 1'($urandom);
                instr = $urandom;
                fin = st && mem_ready;
                run = fin ? rn : 1'($urandom);
                if (fin) exp_retired++;
                if (!mem_ready) exp_stall++;
                if (i == abort_at) begin
                    #1 chk("mem_before_reset", ev(S_M, 1'b0, 1'b0, 1'b0, 2'b00,
                           ld, st, 1'b0, 1'b0, 1'b1, 4'b0010));
                    rst_n = 1'b0;
                    #1 chk("mem_async_reset", quiet(S_I));
                    release_reset();
                    return;
                end
                step($sformatf("mem[%0d]", i), ev(S_M, 1'b0, 1'b0, 1'b0, 2'b00,
                     ld, st, 1'b0, 1'b0, 1'b1, 4'b0010));
                if (mem_ready) break;
                if (i == TMO) begin
                    fault_hold("mem_timeout");
                    return;
                end
            end
            if (st) begin
                at_idle = !rn;
                return;
            end
        end
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        run = rn;
        exp_retired++;
        step($sformatf("wb_k%0d", k), ev(S_W, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
             1'b0, 1'b1, ld, as, aop));
        at_idle = !rn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 chk("reset_state", quiet(S_I));
        release_reset();
        run = 1'b0;
        mem_ready = 1'b1;
        step("idle_hold0", quiet(S_I));
        step("idle_hold1", quiet(S_I));

        // Three instructions, two memory stalls.
        run_instr(32'h8B030041, 1, 0, 1'b0, 1'b1, -1);
        run_instr(32'hF8408041, 0, 1, 1'b0, 1'b1, -1);
        run_instr(32'h14000004, 0, 0, 1'b0, 1'b1, -1);
        chk_perf("perf3");

        run_instr(32'h8B030041, 0, 0, 1'b0, 1'b1, -1);
        run_instr(32'hF8408041, 0, 3, 1'b0, 1'b1, -1);
        run_instr(32'hB4000041, 0, 0, 1'b1, 1'b1, -1);
        run_instr(32'hB4000041, 0, 0, 1'b0, 1'b1, -1);
        run_instr(32'hCB030041, 0, 0, 1'b0, 1'b0, -1);
        run = 1'b0;
        step("idle_after_sub", quiet(S_I));
        run_instr(32'hF8008041, 2, 0, 1'b0, 1'b1, -1);
        run_instr(32'h8A030041, TMO, 0, 1'b0, 1'b1, -1);
        run_instr(32'hF8408041, 0, TMO, 1'b0, 1'b1, -1);
        run_instr(32'hAA030041, 0, 0, 1'b0, 1'b1, -1);
        chk_perf("perf_mid");

        run_instr(32'h00000000, 0, 0, 1'b0, 1'b1, -1);
        run_instr(32'h8B030041, TMO + 1, 0, 1'b0, 1'b1, -1);
        run_instr(32'hF8408041, 0, TMO + 1, 1'b0, 1'b1, -1);
        run_instr(32'hF8008041, 0, 5, 1'b0, 1'b1, 1);

        for (int n = 0; n < 40; n++) begin
            int          k, fw, mw;
            logic [31:0] ins;
            k   = $urandom_range(0, 8);
            ins = mk_instr(k);
            fw  = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3);
            run_instr(ins, fw, mw, 1'($urandom), $urandom_range(0, 3) != 0, -1);
        end
        chk_perf("perf_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multicycle sequencer for the LEGv8 ARM datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control strobes: PC/IR write, memory request, register write, ALU source and ALU op. It replaces single-cycle control so that instruction and data memory can share one port and take variable latency through a ready handshake. It sits between the shared memory port and the ALU/register file.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready in FETCH/MEM before FAULT; 0 = no timeout
TO_W, 4, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep executing, 0 = stop after current instruction
instr  in  32  instruction register contents (valid from DECODE on)
zero  in  1  ALU zero flag
mem_ready  in  1  memory port completion, one-cycle pulse or level
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR from memory data
pc_write  out  1  update PC
pc_src  out  2  00 = PC+4, 01 = PC + sign-extended branch offset
dmem_read  out  1  data load request
dmem_write  out  1  data store request
reg_write  out  1  register file write enable
mem_to_reg  out  1  1 = writeback from memory, 0 = writeback from ALU
alu_src  out  1  0 = register B, 1 = sign-extended immediate
alu_op  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=7
busy  out  1  state != IDLE and state != FAULT
fault  out  1  sticky; 1 in FAULT

Behaviour:
- Reset (async, any state, mid-memory-op included): state=IDLE, class register=NONE, wait counter=0. All outputs 0 (alu_op=0000, pc_src=00).
- Decode classes, taken from instr in DECODE and latched until next DECODE:
  - B: instr[31:26]=000101
  - CBZ: instr[31:24]=10110100
  - STUR: instr[31:21]=11111000000
  - LDUR: instr[31:21]=11111000010
  - ADD: 10001011000
  - SUB: 11001011000
  - AND: 10001010000
  - ORR: 10101010000
  - Anything else is ILLEGAL.
- IDLE: all strobes 0. If run=1, go to FETCH next cycle.
- FETCH: imem_req=1. Each cycle without mem_ready increments the wait counter. When mem_ready=1, in the same cycle (Mealy): ir_write=1, pc_write=1, pc_src=00; go to DECODE.
- DECODE: latch class. ILLEGAL -> FAULT; else -> EXEC.
- EXEC, by class:
  - ADD/SUB/AND/ORR: alu_src=0, alu_op per class -> WB.
  - LDUR/STUR: alu_src=1, alu_op=0010 -> MEM.
  - B: pc_write=1, pc_src=01, alu_op=0111 -> next.
  - CBZ: alu_src=0, alu_op=0111; pc_write=zero, pc_src=01 -> next.
- MEM: alu_src/alu_op held from EXEC. Assert dmem_read (LDUR) or dmem_write (STUR) until mem_ready, counting waits. On mem_ready: LDUR -> WB, STUR -> next.
- WB: reg_write=1 for exactly one cycle, mem_to_reg=(class==LDUR), ALU controls held -> next.
- "next" = FETCH if run=1 else IDLE. run is sampled only at instruction boundaries; deasserting it mid-instruction completes the instruction.
- Wait counter:
  - Cleared on entry to FETCH/MEM.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0 -> FAULT.
  - If mem_ready=1 in that same cycle, mem_ready wins and there is no fault.
- FAULT: all strobes 0, fault=1. Exit only via rst_n.
- Latency with mem_ready tied 1: R-type 4 cycles, LDUR 5, STUR 4, B/CBZ 3 (FETCH to next FETCH).
- reg_write, dmem_write and pc_write never assert outside the states listed above.

Optional Feature:
ARM_CTRL_PERF_EN:
- Defined: adds outputs retired[31:0] and stall_cycles[31:0].
  - retired increments on each instruction completion (transition to next).
  - stall_cycles increments each FETCH/MEM cycle with mem_ready=0.
  - Both counters reset to 0 by rst_n and wrap modulo 2^32.
- Undefined: neither port nor the counter logic exists.

Test Plan:
- run=1, mem_ready=1, instr=ADD X1,X2,X3 (0x8B030041) -> states 1,2,3,5,1; alu_op=0010, alu_src=0 in EXEC; reg_write=1 for one cycle in WB.
- LDUR (0xF8408041), mem_ready low 3 cycles in MEM -> dmem_read held 4 cycles, alu_op=0010/alu_src=1 held, WB with mem_to_reg=1; total 8 cycles.
- CBZ with zero=1 -> pc_write=1, pc_src=01 in EXEC; repeat with zero=0 -> pc_write=0; each 3 cycles.
- instr=0x00000000 -> DECODE -> FAULT, fault=1, all strobes 0 until rst_n; MEM_TIMEOUT=15 with mem_ready stuck 0 in FETCH -> FAULT after 15 wait cycles.
- rst_n low during MEM of STUR -> dmem_write drops asynchronously, state=0; run drop during EXEC of SUB -> WB completes, then IDLE.
- With ARM_CTRL_PERF_EN: 3 instructions with 2 memory stalls -> retired=3, stall_cycles=2.
